pmem_ram_arbiter: RTL
=====================

# pmem_ram_arbiter

Round-robin arbiter that shares one single-beat RAM request port (the `ram_*` interface driven by the AXI4 pmem bridges) between `NUM_PORTS` requesters. Bursts are locked: a granted port keeps the port until all `len+1` beats are accepted. An in-order routing FIFO steers each `ram_ack_i`/`ram_error_i`/read-data beat back to the port that issued it. It sits between several AXI-to-RAM bridges and the single memory controller.

## Interface
- `NUM_PORTS`, default 2: number of requesters, from 2 to 8.
- `OUTSTANDING`, default 4: routing FIFO depth, which is the maximum number of accepted but unacknowledged beats. Must be a power of 2.
- `clk_i` in 1: clock; all logic is rising-edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `m_wr_i` in 4*NUM_PORTS: per-port write strobes. Slice p is `[4p+3:4p]`.
- `m_rd_i` in NUM_PORTS: per-port read request.
- `m_len_i` in 8*NUM_PORTS: per-port burst length minus 1. Sampled on the first beat only.
- `m_addr_i` in 32*NUM_PORTS: per-port beat address.
- `m_write_data_i` in 32*NUM_PORTS: per-port write data.
- `m_accept_o` out NUM_PORTS: per-port beat accepted this cycle.
- `m_ack_o` out NUM_PORTS: per-port response beat.
- `m_error_o` out NUM_PORTS: per-port error, qualified by `m_ack_o`.
- `m_read_data_o` out 32: `ram_read_data_i` broadcast to all ports.
- `ram_wr_o` out 4, `ram_rd_o` out 1, `ram_len_o` out 8, `ram_addr_o` out 32, `ram_write_data_o` out 32: muxed request to the RAM.
- `ram_accept_i` in 1, `ram_ack_i` in 1, `ram_error_i` in 1, `ram_read_data_i` in 32: RAM handshake and response.

## Operation
- Port p requests when `m_rd_i[p] | (|m_wr_i[p])`.
- A beat is accepted when `ram_rd_o | (|ram_wr_o)`, and `ram_accept_i`, and the FIFO is not full.
- State machine has two states, IDLE and BURST.
- **IDLE**
  - The grant is combinational. It goes to the first requesting port, searching upward with wrap-around from `last_q+1`.
  - On an accepted beat with `len != 0`: go to BURST, set `owner_q = p`, `remain_q = len`.
  - On an accepted beat with `len == 0`: stay in IDLE, set `last_q = p`.
- **BURST**
  - Only `owner_q` is granted. Requests from other ports are ignored and never accepted.
  - On each accepted beat: `remain_q` decrements by 1.
  - When `remain_q == 1` at acceptance: go to IDLE, set `last_q = owner_q`.
- Request mux:
  - `ram_*` request outputs carry the granted port's fields.
  - `ram_rd_o` and `ram_wr_o` are forced to 0 when no port is granted or the FIFO is full.
  - `ram_addr_o`, `ram_write_data_o` and `ram_len_o` are don't-care while gated.
- `m_accept_o[p] = grant[p] & ram_accept_i & !fifo_full`.
- Routing FIFO:
  - Width is `$clog2(NUM_PORTS)`, holding the port index.
  - Push on every accepted beat, read or write.
  - Pop on `ram_ack_i` when not empty.
  - Full/empty come from the registered count. A push is refused when full, even if a pop occurs in the same cycle.
- Response:
  - `m_ack_o = ram_ack_i & !fifo_empty`, one-hot at the FIFO head index.
  - `m_error_o = ram_error_i` at the same index.
  - A `ram_ack_i` arriving while the FIFO is empty is dropped: no ack, FIFO unchanged.
- `remain_q` is 8-bit and never underflows: the BURST exit happens at 1.

## Timing
- Request path is zero-latency. A request presented in cycle N appears on `ram_*` in cycle N, and `m_accept_o` asserts in cycle N if accepted.
- Response path is zero-latency: `ram_ack_i` in cycle N produces `m_ack_o` in cycle N.
- A stall (`ram_accept_i = 0`) holds state, grant, `remain_q` and the FIFO unchanged.
- Back-to-back single beats from different ports run at 1 per cycle with no idle cycle. A newly granted port's first beat may be accepted in the cycle after the previous burst's last beat.
- Reset (`rst_ni = 0` at an edge) applies regardless of in-flight traffic:
  - state goes to IDLE;
  - `last_q = NUM_PORTS-1`, so port 0 wins first;
  - `owner_q = 0`, `remain_q = 0`;
  - FIFO pointers and count go to 0.
- Reset output values:
  - With all inputs low: `ram_wr_o = 0`, `ram_rd_o = 0`, `m_accept_o = 0`, `m_ack_o = 0`, `m_error_o = 0`.
  - Other outputs follow the muxed inputs.
- Reset mid-burst discards the routing entries. Acks arriving later are dropped.

## Test plan
- **Single read:** port 0 read, `len = 0`, `addr = 0x100`, `ram_accept_i = 1`. Required: `ram_rd_o = 1` and `ram_addr_o = 0x100` in the same cycle; `m_accept_o = 01`. An ack 2 cycles later with data `0xCAFE0001` gives `m_ack_o = 01` and `m_read_data_o = 0xCAFE0001`.
- **Fairness:** ports 0 and 1 request single beats continuously. Required: accepted port sequence 0,1,0,1,… with no idle cycles.
- **Burst lock:** port 1 writes with `len = 3`, `wstrb = 0xF`, while port 0 reads continuously. Required: 4 consecutive port-1 beats with `m_accept_o = 10`, then a port-0 grant on the 5th cycle. Acks return in order 1,1,1,1,0.
- **Stall:** mid-burst (`remain_q = 2`), `ram_accept_i = 0` for 3 cycles. Required: grant stays on the owner, `m_accept_o = 0`, `remain_q` stays 2. The burst completes after accept returns.
- **Outstanding limit:** 4 beats accepted with no ack. Required: the 5th request sees `ram_rd_o = 0` and `m_accept_o = 0`. One `ram_ack_i` routes to the oldest port, and the request is accepted the following cycle. A spurious ack while the FIFO is empty produces no `m_ack_o`.
- **Reset mid-operation:** `rst_ni` low mid-burst with 2 beats outstanding. Required: state IDLE and FIFO empty next cycle; subsequent acks are dropped; port 0 wins the first post-reset contest against port 1.

Source files
------------

// File: rtl/pmem_ram_arbiter.sv
// Round-robin arbiter sharing one single-beat RAM request port between NUM_PORTS
// bridges, with burst locking and an in-order FIFO that routes responses back.
module pmem_ram_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [4*NUM_PORTS-1:0]    m_wr_i,
  input  logic [NUM_PORTS-1:0]      m_rd_i,
  input  logic [8*NUM_PORTS-1:0]    m_len_i,
  input  logic [32*NUM_PORTS-1:0]   m_addr_i,
  input  logic [32*NUM_PORTS-1:0]   m_write_data_i,
  output logic [NUM_PORTS-1:0]      m_accept_o,
  output logic [NUM_PORTS-1:0]      m_ack_o,
  output logic [NUM_PORTS-1:0]      m_error_o,
  output logic [31:0]               m_read_data_o,
  output logic [3:0]                ram_wr_o,
  output logic                      ram_rd_o,
  output logic [7:0]                ram_len_o,
  output logic [31:0]               ram_addr_o,
  output logic [31:0]               ram_write_data_o,
  input  logic                      ram_accept_i,
  input  logic                      ram_ack_i,
  input  logic                      ram_error_i,
  input  logic [31:0]               ram_read_data_i,
  output logic                      dbg_state_o
);

  localparam int IW  = $clog2(NUM_PORTS);
  localparam int NP2 = 1 << IW;
  localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW  = $clog2(OUTSTANDING + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      remain_q, remain_d;

  // Per-port fields unpacked and padded to a power of two so any index is legal.
  logic [NP2-1:0]  req;
  logic [NP2-1:0]  rd_a;
  logic [3:0]      wr_a    [NP2];
  logic [7:0]      len_a   [NP2];
  logic [31:0]     addr_a  [NP2];
  logic [31:0]     wdata_a [NP2];

  for (genvar p = 0; p < NP2; p++) begin : g_port
    if (p < NUM_PORTS) begin : g_real
      assign rd_a[p]    = m_rd_i[p];
      assign wr_a[p]    = m_wr_i[4*p +: 4];
      assign len_a[p]   = m_len_i[8*p +: 8];
      assign addr_a[p]  = m_addr_i[32*p +: 32];
      assign wdata_a[p] = m_write_data_i[32*p +: 32];
    end else begin : g_pad
      assign rd_a[p]    = 1'b0;
      assign wr_a[p]    = 4'b0;
      assign len_a[p]   = 8'b0;
      assign addr_a[p]  = 32'b0;
      assign wdata_a[p] = 32'b0;
    end
    assign req[p] = rd_a[p] | (|wr_a[p]);
  end

  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  int              cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = owner_q;
    cand      = 0;
    if (state_q == ST_BURST) begin
      grant_vld = req[owner_q];
    end else begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        cand = int'(last_q) + i;
        if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
        if (!grant_vld && req[IW'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = IW'(cand);
        end
      end
    end
  end

  // Routing FIFO of port indices, one entry per accepted beat.
  logic [IW-1:0]   fifo_mem [OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            fifo_full, fifo_empty, push, pop, gate, beat_acc;
  logic [IW-1:0]   head;

  assign fifo_full  = (count_q == CW'(OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];

  // Handshake: a beat transfers in the cycle where ram_rd_o/ram_wr_o request it
  // and ram_accept_i is high; the request stays presented until that happens.
  assign gate             = grant_vld & ~fifo_full;
  assign ram_rd_o         = gate & rd_a[grant_idx];
  assign ram_wr_o         = gate ? wr_a[grant_idx] : 4'b0;
  assign ram_len_o        = len_a[grant_idx];
  assign ram_addr_o       = addr_a[grant_idx];
  assign ram_write_data_o = wdata_a[grant_idx];
  assign beat_acc         = (ram_rd_o | (|ram_wr_o)) & ram_accept_i;
  assign push             = beat_acc;
  assign pop              = ram_ack_i & ~fifo_empty;
  assign m_read_data_o    = ram_read_data_i;
  assign dbg_state_o      = state_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      m_accept_o[p] = beat_acc && (grant_idx == IW'(p));
      m_ack_o[p]    = pop && (head == IW'(p));
      m_error_o[p]  = pop && ram_error_i && (head == IW'(p));
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          if (ram_len_o != 8'd0) begin
            state_d  = ST_BURST;
            owner_d  = grant_idx;
            remain_d = ram_len_o;
          end else begin
            last_d = grant_idx;
          end
        end
      end
      ST_BURST: begin
        if (beat_acc) begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(NUM_PORTS - 1);
      owner_q  <= '0;
      remain_q <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      remain_q <= remain_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= grant_idx;
  end

endmodule
